sign_narrower_16in_12out: RTL and testbench
===========================================

Name: sign_narrower_16in_12out

Overview:
- Inverse of the 12→16 sign extender: converts 16-bit two's-complement datapath values back into 12-bit signed immediate/offset fields, e.g. for branch-offset and immediate encoding in the writeback/encode path.
- Registered stream stage with a valid/ready handshake on both sides and a 2-entry buffer, so full throughput is sustained under backpressure.
- Detects range overflow per item, and keeps a sticky overflow flag and a saturating overflow counter for debug/status.

Parameters:
- OVF_CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready.
- in_data  input  16  signed source value.
- out_valid  output  1  out_data/out_ovf are valid.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- out_data  output  12  narrowed signed value.
- out_ovf  output  1  this item did not fit in 12 bits signed.
- ovf_clear  input  1  clears ovf_sticky and ovf_count.
- ovf_sticky  output  1  set by any accepted overflowing item.
- ovf_count  output  OVF_CNT_W  count of accepted overflowing items, saturating.

Behaviour:
- Fit rule: in_data fits iff in_data[15:11] is all 0s or all 1s (range -2048..2047).
- Narrowed value: in_data[11:0] (wrap), unless the optional feature below is enabled.
- ovf bit: !fit, computed at accept time and stored with the data.
- Buffer: 2-entry FIFO with states EMPTY, ONE, FULL.
  - in_ready = (state != FULL); registered, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - out_data/out_ovf present the head entry.
- State transitions (push = input transfer, pop = output transfer):
  - EMPTY + push → ONE.
  - ONE + push only → FULL.
  - ONE + pop only → EMPTY.
  - ONE + push + pop → ONE.
  - FULL + pop → ONE. No push is possible in FULL.
- Latency: an item accepted in cycle N appears on out_data in cycle N+1 if the buffer was EMPTY.
- Order is preserved.
- Head stability: while out_valid && !out_ready, out_data and out_ovf hold stable.
- Throughput: 1 item/cycle when out_ready is held high.
- ovf_sticky: set on any push with ovf=1.
  - ovf_clear clears it.
  - Same-cycle push-with-ovf and ovf_clear: sticky ends at 1 and count ends at 1 (set wins over clear).
- ovf_count: increments by 1 per overflowing push; holds at all-ones (saturates, no wrap).
  - ovf_clear zeroes it, subject to the same-cycle rule above.
- Reset values: state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0.
- Reset mid-operation: buffered items are discarded. in_ready is 1 from the first cycle after reset deasserts.
- in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: SIGN_NARROWER_SATURATE_EN.
- Defined: non-fitting values clamp to 12'h7FF (positive, in_data[15]=0) or 12'h800 (negative, in_data[15]=1). out_ovf, ovf_sticky and ovf_count behave as normal.
- Undefined: out_data = in_data[11:0] (wrap). Overflow reporting is identical.

Test Plan:
- Reset, then push 16'hFFFF, 16'h07FF, 16'hF800 with out_ready=1 → out_data 12'hFFF, 12'h7FF, 12'h800 on consecutive cycles; out_ovf=0 on all; ovf_count=0.
- Push 16'h0800 → out_ovf=1, ovf_sticky=1, ovf_count=1; out_data=12'h800 (wrap) or 12'h7FF (SATURATE_EN). Push 16'h8000 → out_data 12'h000 (wrap) or 12'h800 (SATURATE_EN); ovf_count=2.
- Backpressure: hold out_ready=0 and push 16'h0001, 16'h0002 → in_ready=0 after the 2nd accept, out_data stays 12'h001. Raise out_ready → 12'h001 then 12'h002, and in_ready returns to 1 the cycle after the first pop.
- Streaming: continuous in_valid=1 and out_ready=1 for 20 items 0..19 → 20 outputs in order, one per cycle, state never FULL.
- Counter: with OVF_CNT_W=2, push 5 overflowing values → ovf_count=3. Pulse ovf_clear in the same cycle as a 6th overflowing push → ovf_count=1, ovf_sticky=1.
- Assert reset while FULL → next cycle out_valid=0, in_ready=1, ovf_count=0, and the buffered items are never emitted.

Source files
------------

// File: rtl/sign_narrower_16in_12out.sv
// Narrows 16-bit two's-complement values to 12-bit signed fields through a 2-entry stream buffer.
// Define SIGN_NARROWER_SATURATE_EN to clamp out-of-range values instead of wrapping them.
module sign_narrower_16in_12out #(
  parameter int unsigned OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          out_data,
  output logic                 out_ovf,
  input  logic                 ovf_clear,
  output logic                 ovf_sticky,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 12;
  localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [OUT_W-1:0]     head_data_q, head_data_d;
  logic                 head_ovf_q, head_ovf_d;
  logic [OUT_W-1:0]     tail_data_q, tail_data_d;
  logic                 tail_ovf_q, tail_ovf_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sticky_q, sticky_d;
  logic [OVF_CNT_W-1:0] count_q, count_d;

  logic                 fit_c;
  logic                 ovf_c;
  logic [OUT_W-1:0]     narrow_c;
  logic                 push_c;
  logic                 pop_c;

  // Value fits when all bits above the new sign bit replicate it.
  assign fit_c = (&in_data[IN_W-1:OUT_W-1]) | ~(|in_data[IN_W-1:OUT_W-1]);
  assign ovf_c = ~fit_c;

`ifdef SIGN_NARROWER_SATURATE_EN
  assign narrow_c = fit_c ? in_data[OUT_W-1:0]
                          : (in_data[IN_W-1] ? 12'h800 : 12'h7FF);
`else
  assign narrow_c = in_data[OUT_W-1:0];
`endif

  assign push_c = in_valid & in_ready_q;
  assign pop_c  = out_valid_q & out_ready;

  // Buffer occupancy, entry movement and overflow status.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ovf_d  = head_ovf_q;
    tail_data_d = tail_data_q;
    tail_ovf_d  = tail_ovf_q;
    sticky_d    = sticky_q;
    count_d     = count_q;

    case (state_q)
      ST_EMPTY: begin
        if (push_c) begin
          head_data_d = narrow_c;
          head_ovf_d  = ovf_c;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push_c && pop_c) begin
          head_data_d = narrow_c;
          head_ovf_d  = ovf_c;
        end else if (push_c) begin
          tail_data_d = narrow_c;
          tail_ovf_d  = ovf_c;
          state_d     = ST_FULL;
        end else if (pop_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_c) begin
          head_data_d = tail_data_q;
          head_ovf_d  = tail_ovf_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);

    // A clear coinciding with an overflowing push leaves that push counted.
    if (ovf_clear) begin
      sticky_d = push_c & ovf_c;
      count_d  = (push_c & ovf_c) ? OVF_CNT_W'(1) : '0;
    end else if (push_c && ovf_c) begin
      sticky_d = 1'b1;
      if (count_q != CNT_MAX) begin
        count_d = count_q + OVF_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_ovf_q  <= 1'b0;
      tail_data_q <= '0;
      tail_ovf_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ovf_q  <= head_ovf_d;
      tail_data_q <= tail_data_d;
      tail_ovf_q  <= tail_ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = head_data_q;
  assign out_ovf    = head_ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = count_q;

endmodule

// File: tb/tb_sign_narrower_16in_12out.sv
// Bench for sign_narrower_16in_12out: directed scenarios plus random traffic against a queue model.
module tb_sign_narrower_16in_12out;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [15:0] in_data;
  logic [11:0] out_data;
  logic        ovf_clear, ovf_sticky;
  logic [7:0]  ovf_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_data;
  logic [11:0] b_out_data;
  logic        b_ovf_clear, b_ovf_sticky;
  logic [1:0]  b_ovf_count;

  int checks = 0;
  int passed = 0;

  logic [12:0] mq[$];
  bit          m_sticky;
  int          m_count;

  always #5 clk = ~clk;

  sign_narrower_16in_12out #(.OVF_CNT_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_clear(ovf_clear), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  sign_narrower_16in_12out #(.OVF_CNT_W(2)) u_dut_cnt2 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf),
    .ovf_clear(b_ovf_clear), .ovf_sticky(b_ovf_sticky), .ovf_count(b_ovf_count)
  );

  // Reference conversion from signed-range arithmetic: returns {ovf, data}.
  function automatic logic [12:0] ref_item(input logic [15:0] v);
    int s;
    bit fits;
    logic [11:0] d;
    s    = int'($signed(v));
    fits = (s >= -2048) && (s <= 2047);
    d    = 12'(((s % 4096) + 4096) % 4096);
`ifdef SIGN_NARROWER_SATURATE_EN
    if (!fits) d = (s < 0) ? 12'h800 : 12'h7FF;
`endif
    return {~fits, d};
  endfunction

  function automatic logic [23:0] exp_vec();
    logic [11:0] d;
    logic o;
    d = 12'h0;
    o = 1'b0;
    if (mq.size() > 0) {o, d} = mq[0];
    return {(mq.size() < 2), (mq.size() > 0), d, o, m_sticky, 8'(m_count)};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {in_ready, out_valid, (out_valid ? out_data : 12'h0), (out_valid ? out_ovf : 1'b0),
            ovf_sticky, ovf_count};
  endfunction

  // Advance one clock and move the model by the transfers implied by its own occupancy.
  task automatic tick();
    bit push, pop, povf;
    logic [12:0] it;
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    it   = ref_item(in_data);
    povf = push && it[12];
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      m_sticky = 1'b0;
      m_count  = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(it);
      if (ovf_clear) begin
        m_sticky = povf;
        m_count  = povf ? 1 : 0;
      end else if (povf) begin
        m_sticky = 1'b1;
        if (m_count < 255) m_count++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL reset_hs: valid=%b ready=%b want 0/1", out_valid, in_ready);
    else passed++;
    checks++;
    if (out_data !== 12'h0 || out_ovf !== 1'b0) $display("FAIL reset_data: data=%h ovf=%b want 000/0", out_data, out_ovf);
    else passed++;
    checks++;
    if (ovf_sticky !== 1'b0 || ovf_count !== 8'h0) $display("FAIL reset_ovf: sticky=%b count=%0d want 0/0", ovf_sticky, ovf_count);
    else passed++;
  endtask

  task automatic test_fit();
    logic [15:0] vals[3];
    logic [11:0] want[3];
    vals = '{16'hFFFF, 16'h07FF, 16'hF800};
    want = '{12'hFFF, 12'h7FF, 12'h800};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== want[i] || out_ovf !== 1'b0 || ovf_count !== 8'h0)
        $display("FAIL fit_%0d: v=%b d=%h o=%b c=%0d want 1/%h/0/0", i, out_valid, out_data, out_ovf, ovf_count, want[i]);
      else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL fit_drain: got %h want %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_overflow();
    logic [11:0] w0, w1;
`ifdef SIGN_NARROWER_SATURATE_EN
    w0 = 12'h7FF;
    w1 = 12'h800;
`else
    w0 = 12'h800;
    w1 = 12'h000;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0800;
    tick();
    checks++;
    if (out_data !== w0 || out_ovf !== 1'b1 || ovf_sticky !== 1'b1 || ovf_count !== 8'd1)
      $display("FAIL ovf_pos: d=%h o=%b s=%b c=%0d want %h/1/1/1", out_data, out_ovf, ovf_sticky, ovf_count, w0);
    else passed++;
    in_data = 16'h8000;
    tick();
    checks++;
    if (out_data !== w1 || out_ovf !== 1'b1 || ovf_count !== 8'd2)
      $display("FAIL ovf_neg: d=%h o=%b c=%0d want %h/1/2", out_data, out_ovf, ovf_count, w1);
    else passed++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    tick();
    in_data = 16'h0002;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 12'h001) $display("FAIL bp_full: ready=%b d=%h want 0/001", in_ready, out_data);
    else passed++;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_data !== 12'h001 || out_valid !== 1'b1) $display("FAIL bp_hold: d=%h v=%b want 001/1", out_data, out_valid);
      else passed++;
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 12'h002 || in_ready !== 1'b1) $display("FAIL bp_pop1: d=%h ready=%b want 002/1", out_data, in_ready);
    else passed++;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL bp_drain: got %h want %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 16'(k);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 12'(k) || in_ready !== 1'b1)
        $display("FAIL stream_%0d: v=%b d=%h ready=%b want 1/%h/1", k, out_valid, out_data, in_ready, 12'(k));
      else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL stream_end: valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] edges[10];
    edges = '{16'h07FE, 16'h07FF, 16'h0800, 16'h0801, 16'hF7FF,
              16'hF800, 16'hF801, 16'h8000, 16'h7FFF, 16'hFFFF};
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      ovf_clear = ($urandom % 16) == 0;
      in_data   = (($urandom % 2) == 0) ? edges[$urandom % 10] : 16'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL rand_%0d: got %h want %h", n, obs_vec(), exp_vec());
      else passed++;
    end
    in_valid  = 1'b0;
    ovf_clear = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_counter_sat();
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (b_ovf_count !== 2'((i + 1 > 3) ? 3 : i + 1) || b_ovf_sticky !== 1'b1)
        $display("FAIL cnt2_%0d: count=%0d sticky=%b want %0d/1", i, b_ovf_count, b_ovf_sticky, (i + 1 > 3) ? 3 : i + 1);
      else passed++;
    end
    b_ovf_clear = 1'b1;
    b_in_data   = 16'hC000;
    @(posedge clk);
    #1;
    checks++;
    if (b_ovf_count !== 2'd1 || b_ovf_sticky !== 1'b1) $display("FAIL cnt2_clr_push: count=%0d sticky=%b want 1/1", b_ovf_count, b_ovf_sticky);
    else passed++;
    b_in_valid = 1'b0;
    @(posedge clk);
    #1;
    b_ovf_clear = 1'b0;
    checks++;
    if (b_ovf_count !== 2'd0 || b_ovf_sticky !== 1'b0) $display("FAIL cnt2_clr: count=%0d sticky=%b want 0/0", b_ovf_count, b_ovf_sticky);
    else passed++;
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0123;
    tick();
    in_data = 16'h0FFF;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL rstf_full: ready=%b valid=%b want 0/1", in_ready, out_valid);
    else passed++;
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== 8'h0)
      $display("FAIL rstf_after: valid=%b ready=%b count=%0d want 0/1/0", out_valid, in_ready, ovf_count);
    else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL rstf_ghost_%0d: valid=%b data=%h want 0", i, out_valid, out_data);
      else passed++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 16'h0;
    out_ready   = 1'b0;
    ovf_clear   = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = 16'h0;
    b_out_ready = 1'b0;
    b_ovf_clear = 1'b0;
    m_sticky    = 1'b0;
    m_count     = 0;
    test_reset();
    test_fit();
    test_overflow();
    test_backpressure();
    test_streaming();
    test_random();
    test_counter_sat();
    test_reset_full();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
